fp_sgnj_arbiter: RTL
====================

Name: fp_sgnj_arbiter

Overview:
- Shares one pipelined sign-injection datapath (FSGNJ/FSGNJN/FSGNJX) among NUM_REQ requesters in the FP execute stage.
- Arbitration is round-robin. Each accepted op carries its requester ID and tag through a 1-stage compute register into a 2-entry output FIFO.
- The FIFO drives a single valid/ready result port. Issue is credit-gated so that back-pressure never drops a result.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FP_WIDTH, 32, operand/result width (32 or 64).
- TAG_WIDTH, 4, opaque tag width carried with each op.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous pipeline flush.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- o_req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- i_req_op  in  2*NUM_REQ  per-requester op: 00 SGNJ, 01 SGNJN, 10 SGNJX, 11 illegal.
- i_req_a  in  FP_WIDTH*NUM_REQ  per-requester fs1.
- i_req_b  in  FP_WIDTH*NUM_REQ  per-requester fs2.
- i_req_tag  in  TAG_WIDTH*NUM_REQ  per-requester tag.
- o_res_valid  out  1  result valid.
- i_res_ready  in  1  result consumer ready.
- o_res_data  out  FP_WIDTH  result.
- o_res_id  out  $clog2(NUM_REQ)  originating requester.
- o_res_tag  out  TAG_WIDTH  originating tag.
- o_res_illegal  out  1  op code was 11.
- o_perf_grants  out  32  grant counter (see Optional Feature).
- o_perf_stalls  out  32  stall counter (see Optional Feature).

Behaviour:
- Reset (async, i_rst_n=0):
  - S1 valid, FIFO count, pointers and perf counters go to 0.
  - RR pointer goes to NUM_REQ-1, so req 0 has first priority.
  - All outputs are 0.
  - Reset mid-operation discards all in-flight ops.
- Credit:
  - inflight = s1_valid + fifo_count.
  - can_issue = (inflight < 2) OR (inflight == 2 AND fifo pop this cycle).
  - can_issue = 0 while i_flush=1.
- Grant:
  - When can_issue=1, grant the first asserted i_req_valid searching from RR pointer+1 upward, wrapping at NUM_REQ.
  - o_req_ready is one-hot on the granted index, otherwise 0.
  - o_req_ready depends combinationally on i_req_valid. Requesters must not make valid depend on ready.
  - On a grant, the RR pointer moves to the granted index. With no grant, the pointer holds.
- Compute:
  - result = {sign', a[FP_WIDTH-2:0]}, where sign' is b.sign for SGNJ, ~b.sign for SGNJN, a.sign^b.sign for SGNJX.
  - For op 11: result = a unchanged and the illegal flag is set.
  - The result is registered in S1 together with id and tag.
- FIFO:
  - S1 writes into a 2-entry circular FIFO the cycle after capture.
  - o_res_* is taken from the FIFO head. o_res_valid = (count != 0).
  - Pop on o_res_valid && i_res_ready.
  - Simultaneous push and pop keeps count unchanged. Push when full cannot occur by credit construction (assertion).
- Latency:
  - A request granted in cycle N shows o_res_valid in cycle N+2 when the FIFO is empty.
  - Sustained throughput is 1 op/cycle when i_res_ready=1.
- Ordering: results leave in grant order.
- Output stability: while o_res_valid=1 and i_res_ready=0, all o_res_* outputs hold stable.
- Flush (i_flush=1):
  - Clears S1 valid and FIFO count on the next edge.
  - No grant that cycle. A pop in the same cycle is still honoured on the consumer side but the data is discarded.
  - The RR pointer is preserved.

Optional Feature:
- Macro FP_SGNJ_ARB_PERF_EN.
- Defined:
  - o_perf_grants increments on every grant.
  - o_perf_stalls increments each cycle in which |i_req_valid=1 and no grant occurs.
  - Both are 32-bit, wrap at 2^32, are cleared by reset, and are not cleared by flush.
- Undefined: both outputs tied to 0 and no counter flops are instantiated.

Test Plan:
- Reset, then req0 only: a=0x3F800000, b=0x80000000, op SGNJ granted cycle 0 -> cycle 2: o_res_valid=1, data=0xBF800000, id=0, illegal=0.
- All 4 requesters valid continuously, i_res_ready=1 -> grants 0,1,2,3,0,... one per cycle; results emerge in that order, 2 cycles after each grant.
- i_res_ready=0 with requests pending -> exactly 2 grants then o_req_ready=0; raise ready -> resumes 1/cycle and no result is lost or reordered.
- SGNJX a=0xC0000000, b=0x80000000 -> 0x40000000; SGNJN a=0x40000000, b=0x00000000 -> 0xC0000000; op 11 a=0x12345678 -> 0x12345678 with illegal=1.
- i_flush with 2 results buffered -> o_res_valid=0 the next cycle; the next grant goes to the requester after the last granted one.
- With FP_SGNJ_ARB_PERF_EN: 10 grants plus 3 blocked cycles -> o_perf_grants=10, o_perf_stalls=3. Without the macro: both read 0.

Source files
------------

// File: rtl/fp_sgnj_arbiter.sv
// rtl/fp_sgnj_arbiter.sv - round-robin shared FSGNJ/FSGNJN/FSGNJX unit with credit-gated 2-entry result FIFO
// Optional perf counters enabled by defining FP_SGNJ_ARB_PERF_EN.
module fp_sgnj_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int FP_WIDTH  = 32,
  parameter int TAG_WIDTH = 4,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_flush,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [2*NUM_REQ-1:0]           i_req_op,
  input  logic [FP_WIDTH*NUM_REQ-1:0]    i_req_a,
  input  logic [FP_WIDTH*NUM_REQ-1:0]    i_req_b,
  input  logic [TAG_WIDTH*NUM_REQ-1:0]   i_req_tag,
  output logic                           o_res_valid,
  input  logic                           i_res_ready,
  output logic [FP_WIDTH-1:0]            o_res_data,
  output logic [IDW-1:0]                 o_res_id,
  output logic [TAG_WIDTH-1:0]           o_res_tag,
  output logic                           o_res_illegal,
  output logic [31:0]                    o_perf_grants,
  output logic [31:0]                    o_perf_stalls
);

  localparam int EW = FP_WIDTH + IDW + TAG_WIDTH + 1;

  logic [IDW-1:0]      rr_ptr;
  logic [IDW-1:0]      gnt_idx;
  logic                gnt_any;
  logic                s1_valid;
  logic [EW-1:0]       s1_entry;
  logic [EW-1:0]       fifo_mem [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;
  logic [1:0]          inflight;
  logic                pop;
  logic                push;
  logic                can_issue;
  logic [1:0]          op;
  logic [FP_WIDTH-1:0] a;
  logic                b_sign;
  logic                sign_out;
  logic [FP_WIDTH-1:0] result;
  logic                illegal;
  logic [TAG_WIDTH-1:0] tag;

  assign o_res_valid = (count != 2'd0);
  assign pop         = o_res_valid & i_res_ready;
  assign push        = s1_valid & ~i_flush;
  assign inflight    = {1'b0, s1_valid} + count;
  // A slot freed by this cycle's pop can be reused immediately, keeping 1 op/cycle.
  assign can_issue   = i_rst_n & ~i_flush &
                       ((inflight < 2'd2) | ((inflight == 2'd2) & pop));

  always_comb begin
    int k;
    logic [IDW-1:0] idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    k       = 0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k   = (int'(rr_ptr) + i) % NUM_REQ;
      idx = k[IDW-1:0];
      if (can_issue && !gnt_any && i_req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (gnt_any) o_req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    op       = i_req_op[gnt_idx*2 +: 2];
    a        = i_req_a[gnt_idx*FP_WIDTH +: FP_WIDTH];
    b_sign   = i_req_b[gnt_idx*FP_WIDTH + FP_WIDTH - 1];
    tag      = i_req_tag[gnt_idx*TAG_WIDTH +: TAG_WIDTH];
    sign_out = b_sign;
    illegal  = 1'b0;
    case (op)
      2'b00:   sign_out = b_sign;
      2'b01:   sign_out = ~b_sign;
      2'b10:   sign_out = a[FP_WIDTH-1] ^ b_sign;
      default: begin
        sign_out = a[FP_WIDTH-1];
        illegal  = 1'b1;
      end
    endcase
    result = {sign_out, a[FP_WIDTH-2:0]};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr   <= IDW'(NUM_REQ - 1);
      s1_valid <= 1'b0;
      s1_entry <= '0;
    end else begin
      s1_valid <= gnt_any;
      if (gnt_any) begin
        rr_ptr   <= gnt_idx;
        s1_entry <= {result, gnt_idx, tag, illegal};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (i_flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      assert (!(push && !pop && count == 2'd2));
      if (push) begin
        fifo_mem[wr_ptr] <= s1_entry;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign {o_res_data, o_res_id, o_res_tag, o_res_illegal} = fifo_mem[rd_ptr];

`ifdef FP_SGNJ_ARB_PERF_EN
  logic [31:0] perf_grants;
  logic [31:0] perf_stalls;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perf_grants <= 32'd0;
      perf_stalls <= 32'd0;
    end else begin
      if (gnt_any) perf_grants <= perf_grants + 32'd1;
      if ((|i_req_valid) && !gnt_any) perf_stalls <= perf_stalls + 32'd1;
    end
  end

  assign o_perf_grants = perf_grants;
  assign o_perf_stalls = perf_stalls;
`else
  assign o_perf_grants = 32'd0;
  assign o_perf_stalls = 32'd0;
`endif

endmodule
